// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between two frame sources.
// Each 1- or 2-byte frame is serialised into byte strobes, paced on TX_BUSY.
module uart_tx_arbiter #(
   parameter int unsigned BUSY_TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0_VALID,
   input  logic [15:0] REQ0_DATA,
   input  logic        REQ0_TWO_BYTES,
   output logic        REQ0_READY,
   input  logic        REQ1_VALID,
   input  logic [15:0] REQ1_DATA,
   input  logic        REQ1_TWO_BYTES,
   output logic        REQ1_READY,
   input  logic        TX_BUSY,
   output logic [7:0]  TX_P_DATA,
   output logic        TX_DATA_VALID,
   output logic        GRANT_ID,
   output logic        ARB_BUSY,
   output logic        TX_TIMEOUT
);

   typedef enum logic [2:0] {
      StIdle,
      StGrant,
      StSend,
      StWaitBusy,
      StWaitDone
   } state_e;

   state_e      state_q, state_d;
   logic        win_q, win_d;
   logic        last_grant_q, last_grant_d;
   logic [15:0] data_q, data_d;
   logic        two_q, two_d;
   logic        byte_idx_q, byte_idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  p_data_q, p_data_d;
   logic        grant_id_q, grant_id_d;
   logic        timeout_q, timeout_d;

   logic [15:0] sel_data;
   logic        sel_two;
   logic [31:0] cnt_next;

   assign sel_data = win_q ? REQ1_DATA : REQ0_DATA;
   assign sel_two  = win_q ? REQ1_TWO_BYTES : REQ0_TWO_BYTES;
   assign cnt_next = {24'd0, cnt_q} + 32'd1;

   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      last_grant_d = last_grant_q;
      data_d       = data_q;
      two_d        = two_q;
      byte_idx_d   = byte_idx_q;
      cnt_d        = cnt_q;
      p_data_d     = p_data_q;
      grant_id_d   = grant_id_q;
      timeout_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!TX_BUSY && (REQ0_VALID || REQ1_VALID)) begin
               // On a tie the requester that did not win last time goes next.
               win_d   = (REQ0_VALID && REQ1_VALID) ? ~last_grant_q : REQ1_VALID;
               state_d = StGrant;
            end
         end
         StGrant: begin
            data_d       = sel_data;
            two_d        = sel_two;
            grant_id_d   = win_q;
            last_grant_d = win_q;
            byte_idx_d   = 1'b0;
            p_data_d     = sel_data[7:0];
            state_d      = StSend;
         end
         StSend: begin
            cnt_d   = 8'd0;
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (TX_BUSY) begin
               state_d = StWaitDone;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_next >= BUSY_TIMEOUT) begin
                  timeout_d = 1'b1;
                  state_d   = StIdle;
               end
            end
         end
         StWaitDone: begin
            if (!TX_BUSY) begin
               if (two_q && !byte_idx_q) begin
                  byte_idx_d = 1'b1;
                  p_data_d   = data_q[15:8];
                  state_d    = StSend;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= StIdle;
         win_q        <= 1'b0;
         last_grant_q <= 1'b1;
         data_q       <= 16'd0;
         two_q        <= 1'b0;
         byte_idx_q   <= 1'b0;
         cnt_q        <= 8'd0;
         p_data_q     <= 8'd0;
         grant_id_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_q        <= win_d;
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
         two_q        <= two_d;
         byte_idx_q   <= byte_idx_d;
         cnt_q        <= cnt_d;
         p_data_q     <= p_data_d;
         grant_id_q   <= grant_id_d;
         timeout_q    <= timeout_d;
      end
   end

   // Outputs decode only registered state, so no input reaches an output combinationally.
   assign REQ0_READY    = (state_q == StGrant) && !win_q;
   assign REQ1_READY    = (state_q == StGrant) && win_q;
   assign TX_DATA_VALID = (state_q == StSend);
   assign ARB_BUSY      = (state_q != StIdle);
   assign TX_P_DATA     = p_data_q;
   assign GRANT_ID      = grant_id_q;
   assign TX_TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus hand-written
// sequences for round-robin, busy hold-off, timeout and mid-frame reset.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic [15:0] d0 = 16'h12A5, d1 = 16'hBEEF;
   logic        two0 = 1'b0, two1 = 1'b1;
   logic        r0, r1;
   logic        tx_busy, busy_man = 1'b0, tx_auto = 1'b0;
   logic [7:0]  p_data;
   logic        dv, gid, arb, tmo;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.BUSY_TIMEOUT(8)) dut (
      .CLK(clk), .RST(rst),
      .REQ0_VALID(v0), .REQ0_DATA(d0), .REQ0_TWO_BYTES(two0), .REQ0_READY(r0),
      .REQ1_VALID(v1), .REQ1_DATA(d1), .REQ1_TWO_BYTES(two1), .REQ1_READY(r1),
      .TX_BUSY(tx_busy), .TX_P_DATA(p_data), .TX_DATA_VALID(dv),
      .GRANT_ID(gid), .ARB_BUSY(arb), .TX_TIMEOUT(tmo)
   );

   // Transmitter model: busy for 10 cycles after each strobe.
   int busy_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) busy_cnt <= 0;
      else if (dv) busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = tx_auto ? (busy_cnt != 0) : busy_man;

   logic [13:0] outs;
   assign outs = {r0, r1, dv, p_data, gid, arb, tmo};

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       grant_q[$];
   logic [7:0] byte_q[$];
   int both_cnt = 0;
   int busy_fall_cyc = 0, arb_fall_cyc = 0;
   logic busy_prev = 1'b0, arb_prev = 1'b0;
   always @(negedge clk) begin
      if (r0) grant_q.push_back(1'b0);
      if (r1) grant_q.push_back(1'b1);
      if (r0 && r1) both_cnt <= both_cnt + 1;
      if (dv) byte_q.push_back(p_data);
      if (busy_prev && !tx_busy) busy_fall_cyc <= cyc;
      if (arb_prev && !arb) arb_fall_cyc <= cyc;
      busy_prev <= tx_busy;
      arb_prev  <= arb;
   end

   function automatic logic [13:0] mk(logic a, logic b, logic s, logic [7:0] pd, logic g,
                                      logic busy, logic t);
      return {a, b, s, pd, g, busy, t};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      v0 = 1'b0;
      v1 = 1'b0;
      busy_man = 1'b0;
      repeat (2) step();
      rst = 1'b0;
   endtask

   function automatic logic [63:0] pack_bytes(int base, int n);
      logic [63:0] b = '0;
      for (int i = 0; i < n; i++) begin
         if (base + i < byte_q.size()) b = {b[55:0], byte_q[base + i]};
         else b = {b[55:0], 8'hxx};
      end
      return b;
   endfunction

   typedef struct {
      logic        v0;
      logic        v1;
      logic        busy;
      logic [13:0] exp;
   } vec_t;

   vec_t tbl[17];

   initial begin
      int gbase, bbase, k, n;
      tbl[0]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 8'h00, 0, 1, 0)};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, mk(0, 0, 1, 8'hEF, 1, 1, 0)};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 8'hEF, 1, 1, 0)};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, mk(0, 0, 0, 8'hEF, 1, 1, 0)};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, mk(0, 0, 0, 8'hEF, 1, 1, 0)};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, mk(0, 0, 1, 8'hBE, 1, 1, 0)};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 8'hBE, 1, 1, 0)};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, mk(0, 0, 0, 8'hBE, 1, 1, 0)};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 8'hBE, 1, 0, 0)};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, mk(1, 0, 0, 8'hBE, 1, 1, 0)};
      tbl[10] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 1, 8'hA5, 0, 1, 0)};
      tbl[11] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 8'hA5, 0, 1, 0)};
      tbl[12] = '{1'b0, 1'b0, 1'b1, mk(0, 0, 0, 8'hA5, 0, 1, 0)};
      tbl[13] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0, 8'hA5, 0, 0, 0)};
      tbl[14] = '{1'b0, 1'b1, 1'b1, mk(0, 0, 0, 8'hA5, 0, 0, 0)};
      tbl[15] = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 8'hA5, 0, 1, 0)};
      tbl[16] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 1, 8'hEF, 1, 1, 0)};

      // Reset state and per-cycle vector table (transmitter busy driven by table).
      repeat (2) step();
      chk("reset_outputs", outs, 14'd0);
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         v0 = tbl[i].v0;
         v1 = tbl[i].v1;
         busy_man = tbl[i].busy;
         step();
         chk($sformatf("vec%0d", i), outs, tbl[i].exp);
      end

      // Single-byte frame from requester 0 with the 10-cycle transmitter model.
      do_reset();
      tx_auto = 1'b1;
      gbase = grant_q.size();
      bbase = byte_q.size();
      v0 = 1'b1;
      repeat (30) begin
         step();
         if (r0) v0 = 1'b0;
      end
      chk("single_ready_count", grant_q.size() - gbase, 1);
      chk("single_byte_count", byte_q.size() - bbase, 1);
      chk("single_byte_value", pack_bytes(bbase, 1), 64'hA5);
      chk("arb_falls_after_busy", arb_fall_cyc - busy_fall_cyc, 1);

      // Both requesters held valid: strict alternation from reset.
      do_reset();
      tx_auto = 1'b1;
      gbase = grant_q.size();
      bbase = byte_q.size();
      v0 = 1'b1;
      v1 = 1'b1;
      n = 0;
      k = 0;
      while (n < 4 && k < 400) begin
         step();
         k++;
         if (r0 || r1) n++;
         if (n == 4) begin
            v0 = 1'b0;
            v1 = 1'b0;
         end
      end
      k = 0;
      while (arb && k < 100) begin
         step();
         k++;
      end
      chk("rr_grant_count", grant_q.size() - gbase, 4);
      chk("rr_order", (grant_q.size() - gbase == 4) ?
          {grant_q[gbase], grant_q[gbase + 1], grant_q[gbase + 2], grant_q[gbase + 3]} : 4'hx,
          4'b0101);
      chk("rr_bytes", pack_bytes(bbase, 6), 64'hA5EFBEA5EFBE);
      chk("rr_no_double_ready", both_cnt, 0);

      // Transmitter busy holds off the grant; then a stuck transmitter times out.
      do_reset();
      tx_auto = 1'b0;
      gbase = grant_q.size();
      bbase = byte_q.size();
      busy_man = 1'b1;
      v0 = 1'b1;
      repeat (5) step();
      chk("busy_blocks_ready", grant_q.size() - gbase, 0);
      busy_man = 1'b0;
      step();
      chk("ready_after_busy_drop", {r0, r1}, 2'b10);
      v0 = 1'b0;
      v1 = 1'b1;
      step();
      chk("timeout_strobe", {dv, p_data}, {1'b1, 8'hA5});
      step();
      k = 0;
      while (!tmo && k < 20) begin
         step();
         k++;
      end
      chk("timeout_latency", k, 8);
      chk("timeout_back_idle", arb, 1'b0);
      step();
      chk("pending_req1_granted", {r1, r0, tmo}, 3'b100);
      v1 = 1'b0;
      tx_auto = 1'b1;
      k = 0;
      while (arb && k < 60) begin
         step();
         k++;
      end
      chk("after_timeout_bytes", pack_bytes(bbase, 3), 64'hA5EFBE);

      // Reset during WAIT_DONE of the second byte of a requester-0 frame.
      tx_auto = 1'b0;
      busy_man = 1'b0;
      two0 = 1'b1;
      v0 = 1'b1;
      step();
      chk("midframe_grant", {r0, r1}, 2'b10);
      v0 = 1'b0;
      step();
      busy_man = 1'b1;
      step();
      step();
      busy_man = 1'b0;
      step();
      chk("second_byte_strobe", {dv, p_data}, {1'b1, 8'h12});
      busy_man = 1'b1;
      step();
      step();
      step();
      chk("midframe_still_busy", {arb, gid}, 2'b10);
      bbase = byte_q.size();
      rst = 1'b1;
      #1;
      chk("midframe_reset_outputs", outs, 14'd0);
      busy_man = 1'b0;
      two0 = 1'b0;
      v0 = 1'b1;
      v1 = 1'b1;
      repeat (3) step();
      chk("no_strobe_in_reset", byte_q.size() - bbase, 0);
      rst = 1'b0;
      step();
      chk("post_reset_req0_first", {r0, r1}, 2'b10);
      v0 = 1'b0;
      v1 = 1'b0;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
